// File: rtl/cache_pkg.sv
// Shared types and helpers for the data-cache refill controller.
package cache_pkg;

    // Refill controller states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RD_REQ = 2'd1,
        WR_REQ = 2'd2,
        FILL   = 2'd3
    } refill_state_t;

    // Number of byte-offset bits inside a 32-bit word.
    localparam int BYTE_OFF_W = 2;

    // Clear the byte-offset bits so memory only ever sees word addresses.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        word_align = addr & ~((32'd1 << BYTE_OFF_W) - 32'd1);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             inc,
    output logic [WIDTH-1:0] value
);

    logic [WIDTH-1:0] r_value;

    // Count enabled events until the counter saturates.
    // NOTE: flop state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_value <= '0;
        end else if (inc && (r_value != '1)) begin
            r_value <= r_value + WIDTH'(1);
        end
    end

    assign value = r_value;

endmodule

// File: rtl/cache_refill_ctrl.sv
// Load-miss refill and store write-through controller between the
// direct-mapped data cache and data memory, with hit/miss counters.
module cache_refill_ctrl
    import cache_pkg::*;
#(
    parameter int ADDRESS_WIDTH  = 17,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic                     load_i,
    input  logic                     store_i,
    input  logic [ADDRESS_WIDTH-1:0] A_i,
    input  logic [DATA_WIDTH-1:0]    WD_i,
    input  logic [3:0]               BE_i,
    input  logic                     hit_i,
    output logic                     stall_o,
    output logic [DATA_WIDTH-1:0]    FoundData_o,
    output logic                     fill_o,
    output logic                     mem_req_o,
    output logic                     mem_we_o,
    output logic [ADDRESS_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0]    mem_wd_o,
    output logic [3:0]               mem_be_o,
    input  logic                     mem_ack_i,
    input  logic [DATA_WIDTH-1:0]    mem_rd_i,
    output logic                     timeout_o,
    output logic [CNT_WIDTH-1:0]     hit_cnt_o,
    output logic [CNT_WIDTH-1:0]     miss_cnt_o
);

    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

    refill_state_t            r_state;
    logic [WAIT_W-1:0]        r_wait_cnt;
    logic                     r_mem_req;
    logic                     r_mem_we;
    logic [ADDRESS_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0]    r_mem_wd;
    logic [3:0]               r_mem_be;
    logic [DATA_WIDTH-1:0]    r_found;
    logic                     r_fill;
    logic                     r_timeout;

    logic                     w_idle;
    logic                     w_take_store;
    logic                     w_take_miss;
    logic                     w_hit_inc;
    logic                     w_wait_done;
    logic [ADDRESS_WIDTH-1:0] w_aligned_addr;

    // A store wins over a simultaneous load; the load is then not counted.
    assign w_idle         = (r_state == IDLE);
    assign w_take_store   = w_idle && store_i;
    assign w_take_miss    = w_idle && !store_i && load_i && !hit_i;
    assign w_hit_inc      = w_idle && !store_i && load_i && hit_i;
    assign w_wait_done    = (r_wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1));
    assign w_aligned_addr = ADDRESS_WIDTH'(word_align(32'(A_i)));

    // Stall is combinational in IDLE so the pipeline cannot advance past the access that starts a transaction.
    assign stall_o = !w_idle || w_take_store || w_take_miss;

    // Transaction FSM: latch the access, run the req/ack handshake, bound the wait.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state    <= IDLE;
            r_wait_cnt <= '0;
            r_mem_req  <= 1'b0;
            r_mem_we   <= 1'b0;
            r_mem_addr <= '0;
            r_mem_wd   <= '0;
            r_mem_be   <= '0;
            r_found    <= '0;
            r_fill     <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_fill <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_take_store) begin
                        r_mem_addr <= w_aligned_addr;
                        r_mem_wd   <= WD_i;
                        r_mem_be   <= BE_i;
                        r_mem_we   <= 1'b1;
                        r_mem_req  <= 1'b1;
                        r_wait_cnt <= '0;
                        r_state    <= WR_REQ;
                    end else if (w_take_miss) begin
                        r_mem_addr <= w_aligned_addr;
                        r_mem_we   <= 1'b0;
                        r_mem_req  <= 1'b1;
                        r_wait_cnt <= '0;
                        r_state    <= RD_REQ;
                    end
                end
                RD_REQ: begin
                    if (mem_ack_i) begin
                        r_found   <= mem_rd_i;
                        r_mem_req <= 1'b0;
                        r_fill    <= 1'b1;
                        r_state   <= FILL;
                    end else if (w_wait_done) begin
                        r_timeout <= 1'b1;
                        r_mem_req <= 1'b0;
                        r_state   <= IDLE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
                    end
                end
                WR_REQ: begin
                    if (mem_ack_i) begin
                        r_mem_req <= 1'b0;
                        r_state   <= IDLE;
                    end else if (w_wait_done) begin
                        r_timeout <= 1'b1;
                        r_mem_req <= 1'b0;
                        r_state   <= IDLE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
                    end
                end
                FILL: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    sat_counter #(.WIDTH(CNT_WIDTH)) u_hit_cnt (
        .CLK   (CLK),
        .RST_N (RST_N),
        .inc   (w_hit_inc),
        .value (hit_cnt_o)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_miss_cnt (
        .CLK   (CLK),
        .RST_N (RST_N),
        .inc   (w_take_miss),
        .value (miss_cnt_o)
    );

    assign FoundData_o = r_found;
    assign fill_o      = r_fill;
    assign mem_req_o   = r_mem_req;
    assign mem_we_o    = r_mem_we;
    assign mem_addr_o  = r_mem_addr;
    assign mem_wd_o    = r_mem_wd;
    assign mem_be_o    = r_mem_be;
    assign timeout_o   = r_timeout;

endmodule
